// File: rtl/sram_arb_pkg.sv
// Shared types and limits for the SRAM round-robin arbiter.
package sram_arb_pkg;

  localparam int unsigned MaxPorts = 8;
  localparam int unsigned CntWidth = 16;
  localparam int unsigned PortIdW  = $clog2(MaxPorts);

  // One entry of the single-stage response pipe.
  typedef struct packed {
    logic               valid;
    logic [PortIdW-1:0] port_id;
    logic               is_read;
    logic               err;
  } rsp_pipe_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr_i is always < N, so a single subtract wraps the scan.
      cand = 32'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!any_o && req_i[IW'(cand)]) begin
        any_o            = 1'b1;
        gnt_o[IW'(cand)] = 1'b1;
        idx_o            = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM macro between N_PORTS requesters.
// Define SRAM_ARB_PERF_EN to add per-port stall counters (stall_cnt_o, stall_clr_i).
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned N_PORTS         = 2,
  parameter int unsigned SRAM_WORD_DEPTH = 512,
  parameter int unsigned SRAM_BLOCK_SIZE = 4,
  parameter int unsigned ADDR_WIDTH      = 16,
  localparam int unsigned AW             = $clog2(SRAM_WORD_DEPTH),
  localparam int unsigned DW             = 8 * SRAM_BLOCK_SIZE,
  localparam int unsigned PW             = $clog2(N_PORTS)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
`ifdef SRAM_ARB_PERF_EN
  input  logic                            stall_clr_i,
  output logic [N_PORTS*CntWidth-1:0]     stall_cnt_o,
`endif
  input  logic [N_PORTS-1:0]              req_valid_i,
  output logic [N_PORTS-1:0]              req_ready_o,
  input  logic [N_PORTS-1:0]              req_we_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [N_PORTS*DW-1:0]           req_wdata_i,
  input  logic [N_PORTS*SRAM_BLOCK_SIZE-1:0] req_wstrb_i,
  output logic [N_PORTS-1:0]              rsp_valid_o,
  output logic [DW-1:0]                   rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic                            sram_en_o,
  output logic                            sram_we_o,
  output logic [AW-1:0]                   sram_addr_o,
  output logic [DW-1:0]                   sram_wdata_o,
  output logic [SRAM_BLOCK_SIZE-1:0]      sram_wstrb_o,
  input  logic [DW-1:0]                   sram_rdata_i
);

  localparam int unsigned CmpW = ADDR_WIDTH + 1;

  logic [PW-1:0]              ptr_q, ptr_d, win_idx;
  logic [N_PORTS-1:0]         req_gated, gnt;
  logic                       accept, win_we, in_range;
  logic [ADDR_WIDTH-1:0]      win_addr;
  logic [DW-1:0]              win_wdata;
  logic [SRAM_BLOCK_SIZE-1:0] win_wstrb;
  rsp_pipe_t                  rsp_q, rsp_d;

  // Nothing is granted while reset is held.
  assign req_gated = rst_i ? '0 : req_valid_i;

  rr_pick #(
    .N  (N_PORTS),
    .IW (PW)
  ) u_pick (
    .req_i (req_gated),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (accept)
  );

  assign req_ready_o = gnt;

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_wstrb = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (gnt[i]) begin
        win_we    = req_we_i[i];
        win_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = req_wdata_i[i*DW +: DW];
        win_wstrb = req_wstrb_i[i*SRAM_BLOCK_SIZE +: SRAM_BLOCK_SIZE];
      end
    end
  end

  // Widen by one bit so a depth equal to 2**ADDR_WIDTH still compares correctly.
  assign in_range = ({1'b0, win_addr} < CmpW'(SRAM_WORD_DEPTH));

  assign sram_en_o    = accept & in_range;
  assign sram_we_o    = accept & in_range & win_we;
  assign sram_addr_o  = win_addr[AW-1:0];
  assign sram_wdata_o = win_wdata;
  assign sram_wstrb_o = win_wstrb;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (win_idx == PW'(N_PORTS - 1)) ? '0 : win_idx + PW'(1);
    end
  end

  always_comb begin
    rsp_d         = '0;
    rsp_d.valid   = accept;
    rsp_d.port_id = PortIdW'(win_idx);
    rsp_d.is_read = accept & ~win_we;
    rsp_d.err     = accept & ~in_range;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      rsp_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rsp_q <= rsp_d;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      rsp_valid_o[i] = rsp_q.valid && (rsp_q.port_id == PortIdW'(i));
    end
  end

  assign rsp_err_o = rsp_q.err;

  // Macro read data lands in the response cycle; mask it for writes and errors.
  assign rsp_rdata_o = (rsp_q.valid && rsp_q.is_read && !rsp_q.err) ? sram_rdata_i : '0;

`ifdef SRAM_ARB_PERF_EN
  logic [N_PORTS-1:0][CntWidth-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (req_valid_i[i] && !req_ready_o[i] && (stall_cnt_q[i] != '1)) begin
        stall_cnt_d[i] = stall_cnt_q[i] + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || stall_clr_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter: spec-level model plus directed literal checks.
module tb_sram_rr_arbiter;

  localparam int NP    = 3;
  localparam int DEPTH = 512;
  localparam int BS    = 4;
  localparam int AWID  = 16;
  localparam int DW    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [NP*AWID-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP*BS-1:0] req_wstrb;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             sram_en, sram_we;
  logic [8:0]       sram_addr;
  logic [DW-1:0]    sram_wdata;
  logic [DW-1:0]    sram_rdata;
  logic [BS-1:0]    sram_wstrb;
`ifdef SRAM_ARB_PERF_EN
  logic             stall_clr;
  logic [NP*16-1:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int rsp_cnt[NP];

  logic [31:0] sram_mem[DEPTH];
  logic [31:0] ref_mem[DEPTH];

  // Reference model state: pointer and expected response for the current cycle.
  int          m_ptr;
  bit          m_rv;
  int          m_port;
  bit          m_err;
  logic [31:0] m_rdata;

  sram_rr_arbiter #(
    .N_PORTS         (NP),
    .SRAM_WORD_DEPTH (DEPTH),
    .SRAM_BLOCK_SIZE (BS),
    .ADDR_WIDTH      (AWID)
  ) dut (
`ifdef SRAM_ARB_PERF_EN
    .stall_clr_i  (stall_clr),
    .stall_cnt_o  (stall_cnt),
`endif
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_wstrb_i  (req_wstrb),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .sram_en_o    (sram_en),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_wstrb_o (sram_wstrb),
    .sram_rdata_i (sram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port macro with one-cycle read latency.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < BS; b++) begin
          if (sram_wstrb[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid port scanning from ptr, or -1.
  function automatic int pick(input logic [NP-1:0] v, input int ptr);
    for (int k = 0; k < NP; k++) begin
      if (v[(ptr + k) % NP]) return (ptr + k) % NP;
    end
    return -1;
  endfunction

  initial begin : model
    int w;
    int a;
    m_ptr = 0; m_rv = 0; m_port = 0; m_err = 0; m_rdata = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ptr = 0; m_rv = 0; m_err = 0; m_rdata = '0;
      end else begin
        w = pick(req_valid, m_ptr);
        if (w < 0) begin
          m_rv = 0; m_err = 0; m_rdata = '0;
        end else begin
          a       = int'(req_addr[w*AWID +: AWID]);
          m_rv    = 1;
          m_port  = w;
          m_err   = (a >= DEPTH);
          m_rdata = '0;
          if (!m_err) begin
            if (req_we[w]) begin
              for (int b = 0; b < BS; b++) begin
                if (req_wstrb[w*BS + b]) ref_mem[a][b*8 +: 8] = req_wdata[w*DW + b*8 +: 8];
              end
            end else begin
              m_rdata = ref_mem[a];
            end
          end
          m_ptr = (w + 1) % NP;
        end
      end
    end
  end

  initial begin : compare
    int w;
    int a;
    logic [NP-1:0] eg;
    logic een, ewe;
    forever begin
      @(negedge clk);
      eg = '0; een = 0; ewe = 0; a = 0;
      w = rst ? -1 : pick(req_valid, m_ptr);
      if (w >= 0) begin
        eg[w] = 1'b1;
        a     = int'(req_addr[w*AWID +: AWID]);
        een   = (a < DEPTH);
        ewe   = een && req_we[w];
      end
      chk("ready", req_ready, eg);
      chk("sram_en", sram_en, een);
      chk("sram_we", sram_we, ewe);
      if (een) begin
        chk("sram_addr", sram_addr, a);
        chk("sram_wdata", sram_wdata, req_wdata[w*DW +: DW]);
        chk("sram_wstrb", sram_wstrb, req_wstrb[w*BS +: BS]);
      end
      chk("rsp_valid", rsp_valid, m_rv ? (1 << m_port) : 0);
      chk("rsp_err", rsp_err, m_rv & m_err);
      chk("rsp_rdata", rsp_rdata, m_rv ? m_rdata : 32'h0);
      if (m_rv) rsp_cnt[m_port]++;
    end
  end

  // Hold a request until accepted, then sample its response one cycle later.
  task automatic do_req(input int p, input logic we, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws,
                        output logic gv, output logic [31:0] rd, output logic ge,
                        output logic en_seen);
    bit ok = 0;
    req_we[p] = we;
    req_addr[p*AWID +: AWID] = addr;
    req_wdata[p*DW +: DW] = wd;
    req_wstrb[p*BS +: BS] = ws;
    req_valid[p] = 1'b1;
    en_seen = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        ok = 1;
        en_seen = sram_en;
      end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    gv = rsp_valid[p];
    rd = rsp_rdata;
    ge = rsp_err;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic gv, ge, en;
    logic [31:0] rd;
    int c0, c1;
    bit ok;
    rst = 1'b1;
    req_valid = 3'b011;
    req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
`ifdef SRAM_ARB_PERF_EN
    stall_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_sram_en", sram_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;

    // Single-port write/read.
    do_req(0, 1'b1, 16'd0, 32'hCAFE0000, 4'hF, gv, rd, ge, en);
    do_req(0, 1'b1, 16'd5, 32'hDEADBEEF, 4'hF, gv, rd, ge, en);
    chk("wr5_rsp", gv, 1);
    chk("wr5_err", ge, 0);
    chk("wr5_rdata", rd, 0);
    do_req(0, 1'b0, 16'd5, 32'h0, 4'h0, gv, rd, ge, en);
    chk("rd5_rsp", gv, 1);
    chk("rd5_rdata", rd, 32'hDEADBEEF);
    chk("rd5_err", ge, 0);

    // Partial write.
    do_req(0, 1'b1, 16'd7, 32'h11223344, 4'hF, gv, rd, ge, en);
    do_req(0, 1'b1, 16'd7, 32'hAABBCCDD, 4'b0101, gv, rd, ge, en);
    do_req(0, 1'b0, 16'd7, 32'h0, 4'h0, gv, rd, ge, en);
    chk("partial_rdata", rd, 32'h11BB33DD);

    // Out-of-range write, then an unaffected read.
    do_req(1, 1'b1, 16'd512, 32'h12345678, 4'hF, gv, rd, ge, en);
    chk("oor_en", en, 0);
    chk("oor_rsp", gv, 1);
    chk("oor_err", ge, 1);
    do_req(0, 1'b0, 16'd0, 32'h0, 4'h0, gv, rd, ge, en);
    chk("after_oor_rdata", rd, 32'hCAFE0000);
    chk("after_oor_err", ge, 0);

    // Two ports continuously valid after reset alternate 0,1,...
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    c0 = rsp_cnt[0];
    c1 = rsp_cnt[1];
    req_we = '0;
    req_addr[0*AWID +: AWID] = 16'd5;
    req_addr[1*AWID +: AWID] = 16'd7;
    req_valid = 3'b011;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("alt_grant", req_ready, (i % 2) ? 3'b010 : 3'b001);
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("alt_rsp_cnt0", rsp_cnt[0] - c0, 4);
    chk("alt_rsp_cnt1", rsp_cnt[1] - c1, 4);

    // Reset right after a read accept drops the response and rewinds the pointer.
    req_addr[0*AWID +: AWID] = 16'd5;
    req_valid = 3'b001;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[0]) ok = 1;
    end
    chk("drop_accept", ok, 1);
    @(posedge clk); #1;
    chk("drop_pre_rsp", rsp_valid, 3'b001);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("drop_rsp", rsp_valid, 0);
    rst = 1'b0;
    req_valid = 3'b011;
    @(negedge clk);
    chk("post_reset_grant", req_ready, 3'b001);
    @(posedge clk); #1;

    // A lone valid port is granted every cycle.
    req_addr[2*AWID +: AWID] = 16'd7;
    req_we[2] = 1'b0;
    req_valid = 3'b100;
    repeat (4) begin
      @(negedge clk);
      chk("lone_grant", req_ready, 3'b100);
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(posedge clk); #1;

`ifdef SRAM_ARB_PERF_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_we = '0;
    req_addr[0*AWID +: AWID] = 16'd5;
    req_addr[1*AWID +: AWID] = 16'd7;
    req_addr[2*AWID +: AWID] = 16'd0;
    req_valid = 3'b111;
    repeat (9) @(posedge clk);
    #1;
    req_valid = '0;
    for (int i = 0; i < NP; i++) chk("stall_cnt", stall_cnt[i*16 +: 16], 16'd6);
    req_valid = 3'b011;
    stall_clr = 1'b1;
    @(posedge clk); #1;
    stall_clr = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NP; i++) chk("stall_clr", stall_cnt[i*16 +: 16], 16'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port SRAM macro (the storage behind axi4_sram) between N_PORTS native requesters, e.g. the AXI4 slave plus a DMA or boot loader.
- Grants at most one request per cycle and drives the macro.
- Routes the 1-cycle-latency read data and write acks back to the granted port.
- Flags out-of-range addresses without touching the macro.

Parameters:
- N_PORTS, 2, number of requesters (2..8).
- SRAM_WORD_DEPTH, 512, words in macro; AW = $clog2(SRAM_WORD_DEPTH).
- SRAM_BLOCK_SIZE, 4, byte lanes per word; DW = 8*SRAM_BLOCK_SIZE.
- ADDR_WIDTH, 16, request word-address width (>= AW).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  N_PORTS  per-port request valid
- req_ready_o  out  N_PORTS  per-port accept (one-hot or zero)
- req_we_i  in  N_PORTS  1 = write
- req_addr_i  in  N_PORTS*ADDR_WIDTH  word address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata_i  in  N_PORTS*DW  write data
- req_wstrb_i  in  N_PORTS*SRAM_BLOCK_SIZE  byte enables
- rsp_valid_o  out  N_PORTS  response strobe, one cycle per accepted request
- rsp_rdata_o  out  DW  read data, shared, qualified by rsp_valid_o
- rsp_err_o  out  1  out-of-range flag, qualified by rsp_valid_o
- sram_en_o  out  1  macro enable
- sram_we_o  out  1  macro write enable
- sram_addr_o  out  AW  macro address
- sram_wdata_o  out  DW  macro write data
- sram_wstrb_o  out  SRAM_BLOCK_SIZE  macro byte enables
- sram_rdata_i  in  DW  macro read data, valid 1 cycle after read enable

Behaviour:
- Reset values:
  - ptr_q = 0; all rsp_valid_o = 0; rsp_err_o = 0; rsp_rdata_o = 0.
  - sram_en_o = 0; sram_we_o = 0.
  - req_ready_o = 0 while rst_i is high.
- Arbitration (combinational, each cycle):
  - Scan ports ptr_q, ptr_q+1, … mod N_PORTS; the first port with req_valid_i high wins.
  - req_ready_o is one-hot on the winner, or zero if no port is valid.
  - Handshake is valid&ready; a valid request must hold its fields stable until accepted.
- Pointer update:
  - On any accept, ptr_q <= winner+1, wrapping from N_PORTS-1 to 0.
  - No accept leaves ptr_q unchanged.
  - Starvation bound: a continuously valid port is accepted within N_PORTS cycles.
- Macro drive (combinational from the winner):
  - sram_en_o = accept && in-range; sram_we_o = accept && we && in-range.
  - sram_addr_o = addr[AW-1:0]; wdata and wstrb pass through.
  - In-range means addr < SRAM_WORD_DEPTH, compared at full ADDR_WIDTH (no truncation before the compare).
- Response pipeline (registered, latency exactly 1 cycle after accept):
  - rsp_valid_o[winner] <= 1 for both reads and writes.
  - rsp_err_o <= !in-range.
  - Response port id is registered alongside.
- Read data:
  - In the response cycle, rsp_rdata_o = sram_rdata_i if the response is an in-range read, else 0.
  - A write or error response returns rdata 0.
- No response backpressure: requesters must sink rsp_valid_o.
- Back-to-back accepts are allowed every cycle (full throughput, one per cycle aggregate).
- Out-of-range access:
  - Request is accepted; macro is not enabled, so no write corruption occurs.
  - Response carries rsp_err_o = 1.
- Simultaneous events:
  - All ports valid: strict rotation.
  - Only one port valid: granted every cycle regardless of ptr_q.
- Reset mid-operation: a pending response in the pipe is dropped (rsp_valid_o = 0 on the next cycle); ptr_q returns to 0.
- No other state exists; the arbiter is otherwise stateless between cycles.

Optional Feature:
- SRAM_ARB_PERF_EN defined:
  - Adds output stall_cnt_o (N_PORTS*16), one counter per port.
  - Counter i increments each cycle req_valid_i[i] && !req_ready_o[i], saturating at 16'hFFFF.
  - Counters clear on rst_i.
  - Adds input stall_clr_i (1), a synchronous clear of all counters; clear wins over increment in the same cycle.
- Not defined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_arb_pkg:
  - Localparams for the maximum port count (8) and counter width (16).
  - Typedef of the response-pipe struct: valid, port_id, is_read, err.
- Sub-module rr_pick: a pure combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, index, any.
  - Reusable by other shared-resource arbiters.

Test Plan:
- Single port: port0 writes addr 5 data 32'hDEADBEEF wstrb 4'hF, then reads addr 5 → rsp_valid_o[0] one cycle after each accept; the read returns 32'hDEADBEEF with err 0.
- Two ports continuously valid for 8 cycles after reset → grants alternate 0,1,0,1,…; each port receives 4 responses.
- Partial write: fill addr 7 with 32'h11223344, write 32'hAABBCCDD wstrb 4'b0101, read back → 32'h11BB33DD.
- Out-of-range: port1 writes addr 512 → accepted; sram_en_o stays 0; rsp_err_o = 1. A following read of addr 0 is unaffected.
- rst_i asserted the cycle after a read accept → no rsp_valid_o next cycle; after release, the first grant with ports 0 and 1 both valid goes to port 0.
- SRAM_ARB_PERF_EN, 3 ports all valid for 9 cycles → each stall_cnt = 6; pulsing stall_clr_i zeroes all counters.
